// File: rtl/player_input_hub_if.sv
// Bundle of joystick inputs, frame handshake and snapshot outputs shared between
// the board top / game-state FSM (master) and the input hub (slave).
interface player_input_hub_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int NUM_BTN     = 5
);
  logic [NUM_PLAYERS*NUM_BTN-1:0] i_btn;
  logic                           i_enable;
  logic                           i_frame;
  logic                           o_valid;
  logic [NUM_PLAYERS*3-1:0]       o_dir;
  logic [NUM_PLAYERS-1:0]         o_fire;
  logic [NUM_PLAYERS*NUM_BTN-1:0] o_led;

  modport master (
    output i_btn, i_enable, i_frame,
    input  o_valid, o_dir, o_fire, o_led
  );

  modport slave (
    input  i_btn, i_enable, i_frame,
    output o_valid, o_dir, o_fire, o_led
  );
endinterface

// File: rtl/player_input_hub.sv
// Joystick front end: synchronise + debounce raw buttons, resolve one direction per
// player, queue fire requests with cooldown, and publish one snapshot per frame tick.
module player_input_hub #(
  parameter int NUM_PLAYERS     = 2,
  parameter int NUM_BTN         = 5,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int FIRE_COOLDOWN   = 8,
  parameter int ACTIVE_LOW_IN   = 0
) (
  input logic               clk,
  input logic               rst_n,
  player_input_hub_if.slave hub
);

  localparam int NB       = NUM_PLAYERS * NUM_BTN;
  localparam int DB_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int CD_W     = (FIRE_COOLDOWN > 0) ? $clog2(FIRE_COOLDOWN + 1) : 1;
  localparam int BIT_UP    = 0;
  localparam int BIT_DOWN  = 1;
  localparam int BIT_LEFT  = 2;
  localparam int BIT_RIGHT = 3;
  localparam int BIT_FIRE  = 4;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0] DB_ONE  = DB_W'(1);
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(FIRE_COOLDOWN);
  localparam logic [CD_W-1:0] CD_ONE  = CD_W'(1);

  logic [NB-1:0]            raw_btn;
  logic [NB-1:0]            sync_q1;
  logic [NB-1:0]            sync_q2;
  logic [NB-1:0]            deb_level;
  logic [DB_W-1:0]          deb_cnt [NB];
  logic [NB-1:0]            led_q;

  logic [NUM_PLAYERS*3-1:0] dir_next;
  logic [NUM_PLAYERS-1:0]   fire_level;
  logic [NUM_PLAYERS-1:0]   fire_prev;
  logic [NUM_PLAYERS-1:0]   fire_edge;
  logic [NUM_PLAYERS-1:0]   pending;
  logic [CD_W-1:0]          cooldown [NUM_PLAYERS];

  logic                     valid_q;
  logic [NUM_PLAYERS*3-1:0] dir_q;
  logic [NUM_PLAYERS-1:0]   fire_q;

  // Inversion happens before synchronisation so everything downstream is active-high.
  assign raw_btn = (ACTIVE_LOW_IN != 0) ? ~hub.i_btn : hub.i_btn;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= raw_btn;
      sync_q2 <= sync_q1;
    end
  end

  // A level is only accepted after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb_level <= '0;
      for (int b = 0; b < NB; b++) deb_cnt[b] <= '0;
    end else begin
      for (int b = 0; b < NB; b++) begin
        if (sync_q2[b] == deb_level[b]) begin
          deb_cnt[b] <= '0;
        end else if (deb_cnt[b] == DB_LAST) begin
          deb_level[b] <= ~deb_level[b];
          deb_cnt[b]   <= '0;
        end else begin
          deb_cnt[b] <= deb_cnt[b] + DB_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) led_q <= '0;
    else        led_q <= deb_level;
  end

  always_comb begin
    dir_next   = '0;
    fire_level = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      fire_level[p] = deb_level[p*NUM_BTN + BIT_FIRE];
      if (deb_level[p*NUM_BTN + BIT_UP])         dir_next[p*3 +: 3] = 3'd1;
      else if (deb_level[p*NUM_BTN + BIT_DOWN])  dir_next[p*3 +: 3] = 3'd2;
      else if (deb_level[p*NUM_BTN + BIT_LEFT])  dir_next[p*3 +: 3] = 3'd3;
      else if (deb_level[p*NUM_BTN + BIT_RIGHT]) dir_next[p*3 +: 3] = 3'd4;
    end
  end

  assign fire_edge = fire_level & ~fire_prev;

  // A delivering tick swallows a coincident edge; a non-delivering tick lets it queue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fire_prev <= '0;
      pending   <= '0;
      for (int p = 0; p < NUM_PLAYERS; p++) cooldown[p] <= '0;
    end else begin
      fire_prev <= fire_level;
      for (int p = 0; p < NUM_PLAYERS; p++) begin
        if (!hub.i_enable) begin
          pending[p]  <= 1'b0;
          cooldown[p] <= '0;
        end else if (hub.i_frame && pending[p]) begin
          pending[p]  <= 1'b0;
          cooldown[p] <= CD_LOAD;
        end else begin
          if (hub.i_frame && (cooldown[p] != '0)) cooldown[p] <= cooldown[p] - CD_ONE;
          if (fire_edge[p] && (cooldown[p] == '0)) pending[p] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      dir_q   <= '0;
      fire_q  <= '0;
    end else begin
      valid_q <= hub.i_frame;
      if (hub.i_frame) begin
        dir_q  <= hub.i_enable ? dir_next : '0;
        fire_q <= hub.i_enable ? pending : '0;
      end
    end
  end

  assign hub.o_valid = valid_q;
  assign hub.o_dir   = dir_q;
  assign hub.o_fire  = fire_q;
  assign hub.o_led   = led_q;

endmodule
